// File: rtl/img_cap_ctrl.sv
// Image capture controller.
// Hands one frame capture at a time to an external image memory (write side),
// then arbitrates two read ports onto the single memory read port once a
// complete frame is held.
module img_cap_ctrl #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIXELS     = IMG_WIDTH * IMG_HEIGHT,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 1024,
   localparam int AW        = $clog2(PIXELS) + 1
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  cap_req,
   output logic                  cap_busy,
   output logic                  cap_done,
   output logic                  cap_err,
   output logic                  frame_valid,
   output logic                  mem_w_req,
   input  logic                  mem_w_busy,
   output logic [AW-1:0]         mem_r_addr,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   input  logic                  rd0_req,
   input  logic [AW-1:0]         rd0_addr,
   output logic                  rd0_gnt,
   output logic                  rd0_valid,
   input  logic                  rd1_req,
   input  logic [AW-1:0]         rd1_addr,
   output logic                  rd1_gnt,
   output logic                  rd1_valid,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ARM       = 2'd1;
   localparam logic [1:0] WAIT_BUSY = 2'd2;
   localparam logic [1:0] CAPT      = 2'd3;

   // Wide enough to hold TIMEOUT-1 without wrapping.
   localparam int CW = $clog2(TIMEOUT) + 1;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          fv_q, fv_d;

   logic          ptr_q, ptr_d;
   logic          gnt0_q, gnt0_d;
   logic          gnt1_q, gnt1_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          vld0_q, vld1_q;
   logic          oob_q;

   logic          rd_allow;
   logic          elig0, elig1;

   // Capture sequencing: next state, timeout counter and capture status pulses.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      fv_d    = fv_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (cap_req) begin
               state_d = ARM;
               // Old frame is about to be overwritten, so it stops being valid
               // as soon as the write request goes out.
               fv_d    = 1'b0;
            end
         end
         ARM: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (mem_w_busy) begin
               state_d = CAPT;
            end else if (cnt_q == CW'(TIMEOUT - 2)) begin
               // Incrementing now would reach TIMEOUT-1: give up.
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CAPT: begin
            if (!mem_w_busy) begin
               state_d = IDLE;
               done_d  = 1'b1;
               fv_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture state and status registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         fv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
      end
   end

   // Round-robin read arbitration; a port granted last cycle sits out one
   // cycle because its request is still visible while it reacts to the grant.
   always_comb begin
      rd_allow = (state_q == IDLE) && fv_q && !cap_req;
      elig0    = rd0_req && !gnt0_q;
      elig1    = rd1_req && !gnt1_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      if (rd_allow) begin
         if (elig0 && elig1) begin
            gnt0_d = !ptr_q;
            gnt1_d = ptr_q;
         end else begin
            gnt0_d = elig0;
            gnt1_d = elig1;
         end
      end
      ptr_d  = ptr_q;
      addr_d = addr_q;
      if (gnt0_d) begin
         ptr_d  = 1'b1;
         addr_d = rd0_addr;
      end else if (gnt1_d) begin
         ptr_d  = 1'b0;
         addr_d = rd1_addr;
      end
   end

   // Grant, read address and read-valid pipeline.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ptr_q  <= 1'b0;
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         addr_q <= '0;
         vld0_q <= 1'b0;
         vld1_q <= 1'b0;
         oob_q  <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         gnt0_q <= gnt0_d;
         gnt1_q <= gnt1_d;
         addr_q <= addr_d;
         vld0_q <= gnt0_q;
         vld1_q <= gnt1_q;
         // Out-of-frame addresses are still served, but their data is forced to 0.
         oob_q  <= (addr_q >= AW'(PIXELS));
      end
   end

   assign cap_busy    = (state_q != IDLE);
   assign mem_w_req   = (state_q == ARM);
   assign cap_done    = done_q;
   assign cap_err     = err_q;
   assign frame_valid = fv_q;
   assign mem_r_addr  = addr_q;
   assign rd0_gnt     = gnt0_q;
   assign rd1_gnt     = gnt1_q;
   assign rd0_valid   = vld0_q;
   assign rd1_valid   = vld1_q;
   assign rd_data     = ((vld0_q || vld1_q) && !oob_q) ? mem_dout : '0;

endmodule

// File: doc/img_cap_ctrl.md
IMG_CAP_CTRL -- requirements
Module: img_cap_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, image width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, image height in lines.
REQ-003 SHALL have parameter PIXELS, default IMG_WIDTH*IMG_HEIGHT, frame size in pixels.
REQ-004 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-005 SHALL have parameter TIMEOUT, default 1024, max cycles from w_req to w_busy rising.
REQ-006 SHALL have ports; AW = $clog2(PIXELS)+1. Single clock; reset asynchronous, active-low:
  clk  in  1  clock
  n_rst  in  1  asynchronous active-low reset
  cap_req  in  1  capture request pulse
  cap_busy  out  1  capture in progress
  cap_done  out  1  one-cycle capture-complete pulse
  cap_err  out  1  one-cycle timeout pulse
  frame_valid  out  1  memory holds a complete frame
  mem_w_req  out  1  write request to image memory
  mem_w_busy  in  1  image memory writing
  mem_r_addr  out  AW  image memory read address
  mem_dout  in  DATA_WIDTH  image memory read data, valid 1 cycle after mem_r_addr
  rd0_req / rd1_req  in  1  read request, level, held with address until grant
  rd0_addr / rd1_addr  in  AW  read address
  rd0_gnt / rd1_gnt  out  1  one-cycle grant
  rd0_valid / rd1_valid  out  1  one-cycle read-data-valid
  rd_data  out  DATA_WIDTH  shared read data

Function
REQ-007 SHALL implement FSM states IDLE, ARM, WAIT_BUSY, CAPT.
REQ-008 IDLE: cap_req=1 -> ARM; cap_req ignored in every other state.
REQ-009 ARM: mem_w_req=1 for exactly this one cycle; frame_valid cleared; -> WAIT_BUSY.
REQ-010 WAIT_BUSY: mem_w_busy=1 -> CAPT; else counter increments; counter reaching TIMEOUT-1 -> IDLE with cap_err=1 for one cycle.
REQ-011 CAPT: mem_w_busy=0 -> IDLE with cap_done=1 and frame_valid=1 set in the same cycle.
REQ-012 cap_busy SHALL be 1 in ARM, WAIT_BUSY, CAPT; 0 in IDLE.
REQ-013 Grants SHALL be issued only in IDLE with frame_valid=1 and cap_req=0; cap_req has priority over new grants in the same cycle.
REQ-014 Grants registered: at most one grant per cycle; round-robin, pointer toggles to the other port after each grant; ties resolved by pointer; pointer reset value = port 0.
REQ-015 A port granted in cycle T SHALL NOT be eligible in cycle T+1 (its req may still be high then).
REQ-016 Grant in cycle T: mem_r_addr = granted address from cycle T (registered, held until the next grant); rdN_valid=1 and rd_data=mem_dout in cycle T+1.
REQ-017 Address >= PIXELS SHALL still be granted; rd_data SHALL be 0 with valid asserted.
REQ-018 rd_data SHALL be 0 whenever both valids are 0.
REQ-019 A read granted before ARM entry SHALL complete its valid cycle normally.
REQ-020 Back-to-back alternating grants (0,1,0,1...) SHALL sustain one read per cycle.

Reset
REQ-021 On n_rst=0, asynchronously: state IDLE, counter 0, pointer 0, all outputs 0 (cap_busy, cap_done, cap_err, frame_valid, mem_w_req, mem_r_addr, gnts, valids, rd_data).
REQ-022 Reset mid-capture SHALL abort; after release frame_valid=0 and no cap_done is issued.

Verification
REQ-023 Reset, cap_req pulse, mem_w_busy high 3 cycles after mem_w_req for 10 cycles -> mem_w_req one cycle, cap_busy high throughout, cap_done and frame_valid rise the cycle after w_busy falls.
REQ-024 Before any capture, rd0_req=1 -> no rd0_gnt ever issued.
REQ-025 After capture, rd0_req and rd1_req held, addresses 5 and 7, mem_dout model = addr -> gnt alternates 0,1,0...; rd_data 5 with rd0_valid, 7 with rd1_valid, one cycle after each gnt.
REQ-026 TIMEOUT=16, mem_w_busy tied 0 -> cap_err pulse 16 cycles after ARM, frame_valid=0, back to IDLE.
REQ-027 rd1_addr=PIXELS -> rd1_gnt, then rd1_valid with rd_data=0.
REQ-028 n_rst asserted during CAPT -> all outputs 0 immediately; new cap_req after release completes a normal capture.
